snax_acc_ordered_router: RTL and testbench
==========================================

// Module: snax_acc_ordered_router
// PURPOSE
// - Routes one Snitch accelerator (CSR) request port to NumAcc accelerator ports, decoding on data_argb.
// - Returns responses to the core strictly in request order using an order FIFO.
// - Sits between the Snitch acc port and the SNAX accelerator shells; successor to the broadcast demux / arbitrated-mux router.
// PARAMETERS
// - NumAcc    2     number of accelerator ports (>=1)
// - NumCsrs   32    CSR window per accelerator
// - CsrBase   960   first CSR address of accelerator 0
// - MaxOutst  4     order-FIFO depth = max outstanding response-expecting requests (>=1)
// - acc_req_t logic request struct {addr, data_arga, data_argb, data_argc, data_op, id}
// - acc_rsp_t logic response struct {id, error, data}
// PORTS
// - clk_i                clock
// - rst_ni               synchronous active-low reset
// - snax_req_i           in   acc_req_t          core request
// - snax_rsp_exp_i       in   1                  request expects one response (CSR read)
// - snax_qvalid_i        in   1                  request valid
// - snax_qready_o        out  1                  request ready
// - snax_resp_o          out  acc_rsp_t          response to core
// - snax_pvalid_o        out  1                  response valid
// - snax_pready_i        in   1                  response ready
// - snax_split_req_o     out  NumAcc x acc_req_t per-accelerator request
// - snax_split_qvalid_o  out  NumAcc             per-accelerator request valid
// - snax_split_qready_i  in   NumAcc             per-accelerator request ready
// - snax_split_resp_i    in   NumAcc x acc_rsp_t per-accelerator response
// - snax_split_pvalid_i  in   NumAcc             per-accelerator response valid
// - snax_split_pready_o  out  NumAcc             per-accelerator response ready
// - outst_cnt_o          out  $clog2(MaxOutst+1) current order-FIFO occupancy
// BEHAVIOUR
// - Decode (32-bit unsigned): off = data_argb - CsrBase; valid iff data_argb >= CsrBase && off < NumAcc*NumCsrs; sel = off / NumCsrs.
// - Forwarded request: all fields copied; data_argb = off - sel*NumCsrs (local offset 0..NumCsrs-1). Unselected ports see the same payload, qvalid 0.
// - Request path combinational, zero latency. Decoded valid: split_qvalid[sel] = qvalid_i && !(rsp_exp && full); qready_o = split_qready[sel] && !(rsp_exp && full).
// - Push {sel, id} to the order FIFO on accepted handshake with rsp_exp=1; rsp_exp=0 pushes nothing.
// - Full blocks push even if a pop occurs in the same cycle; simultaneous push+pop when not full keeps count unchanged.
// - Response path: FIFO empty -> pvalid_o=0, all split_pready=0. Otherwise head.sel=k -> pvalid_o = split_pvalid[k], resp_o = split_resp[k], split_pready[k] = pready_i, others 0.
// - Responses from non-head ports are stalled, never dropped.
// - Pop on pvalid_o && pready_i.
// - Reset (sync, rst_ni=0 at posedge): FIFO emptied, pointers and count = 0; so pvalid_o=0, split_pready=0, outst_cnt_o=0. Request outputs remain combinational.
// - Reset mid-operation discards outstanding order entries; late accelerator responses are then stalled (empty FIFO) until the accelerator is reset too.
// - Pointers wrap modulo MaxOutst (non-power-of-2 supported).
// CONFIGURATION
// - SNAX_ACC_ROUTER_ERR_RSP_EN defined:
//   - Out-of-range request is accepted when (!rsp_exp || !full); no split qvalid is raised.
//   - If rsp_exp, push {ERR, id}, where ERR = index NumAcc.
//   - At head, ERR entry yields local response: pvalid_o=1, resp_o = {id, error=1, data=0}; popped on pready_i.
// - Macro undefined:
//   - Out-of-range request is accepted and dropped (qready_o=1), nothing pushed, no response.
//   - FIFO sel field is $clog2(NumAcc) bits (min 1).
// STRUCTURE
// - Package snax_acc_router_pkg:
//   - default CsrBase (960), default NumCsrs
//   - function csr_decode(addr, base, ncsr, nacc) -> {valid, sel, local_off}
// - Sub-module snax_acc_order_fifo: synchronous FIFO of {sel, id}, depth MaxOutst, sync active-low reset; push/pop/full/empty/head/count.
// TESTING
// - NumAcc=2, NumCsrs=32, CsrBase=960:
//   - write argb=1000, rsp_exp=0 -> split_qvalid=2'b10, split argb=8, outst_cnt 0
// - Read argb=961, then read argb=993, id 3 then 4; acc1 responds first:
//   - acc1 stalled (pready[1]=0)
//   - acc0 response id 3 delivered first, then id 4
//   - outst_cnt 2->1->0
// - MaxOutst=4: issue 4 reads, no responses -> 5th read qready_o=0
//   - pop with push attempted in the same cycle -> push still blocked this cycle, accepted next cycle
//   - writes (rsp_exp=0) still pass when full
// - Read argb=2000, id 7:
//   - with SNAX_ACC_ROUTER_ERR_RSP_EN -> resp {id 7, error 1, data 0} in order
//   - without the macro -> qready_o=1, no pvalid, count 0
// - Backpressure: pready_i=0 for 5 cycles with head valid -> resp_o stable, no pop; NumAcc=3, MaxOutst=3 wrap over 10 reads -> order preserved.
// - Assert rst_ni=0 for 1 cycle with 2 outstanding -> next cycle outst_cnt_o=0, pvalid_o=0, split_pready=0.

Source files
------------

// File: rtl/snax_acc_router_pkg.sv
// Shared types and CSR window decode for the ordered SNAX accelerator router.
package snax_acc_router_pkg;

  localparam int unsigned DefCsrBase = 960;
  localparam int unsigned DefNumCsrs = 32;
  localparam int unsigned IdWidth    = 6;

  typedef struct packed {
    logic [31:0]        addr;
    logic [31:0]        data_arga;
    logic [31:0]        data_argb;
    logic [31:0]        data_argc;
    logic [31:0]        data_op;
    logic [IdWidth-1:0] id;
  } acc_req_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               error;
    logic [31:0]        data;
  } acc_rsp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] sel;
    logic [31:0] local_off;
  } csr_dec_t;

  // Unsigned 32-bit decode; sel and local_off are meaningful only when valid.
  function automatic csr_dec_t csr_decode(input logic [31:0] addr, input logic [31:0] base,
                                          input logic [31:0] ncsr, input logic [31:0] nacc);
    csr_dec_t    dec;
    logic [31:0] off;
    off           = addr - base;
    dec.valid     = (addr >= base) && (off < nacc * ncsr);
    dec.sel       = off / ncsr;
    dec.local_off = off - dec.sel * ncsr;
    return dec;
  endfunction

endpackage

// File: rtl/snax_acc_order_fifo.sv
// Synchronous order FIFO holding {sel, id} of outstanding response-expecting requests.
module snax_acc_order_fifo #(
  parameter int unsigned Depth    = 4,
  parameter int unsigned Width    = 8,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [Width-1:0]    head_o,
  output logic [CntWidth-1:0] count_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // A full FIFO refuses a push even when the same cycle pops.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      wr_d = (wr_q == PtrWidth'(Depth - 1)) ? '0 : wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = (rd_q == PtrWidth'(Depth - 1)) ? '0 : rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/snax_acc_ordered_router.sv
// Routes one Snitch acc request port to NumAcc accelerators and returns responses in request order.
// Define SNAX_ACC_ROUTER_ERR_RSP_EN to answer out-of-range requests with a local error response.
module snax_acc_ordered_router
  import snax_acc_router_pkg::*;
#(
  parameter int unsigned NumAcc   = 2,
  parameter int unsigned NumCsrs  = DefNumCsrs,
  parameter int unsigned CsrBase  = DefCsrBase,
  parameter int unsigned MaxOutst = 4,
  localparam int unsigned CntWidth = $clog2(MaxOutst + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  acc_req_t                     snax_req_i,
  input  logic                         snax_rsp_exp_i,
  input  logic                         snax_qvalid_i,
  output logic                         snax_qready_o,
  output acc_rsp_t                     snax_resp_o,
  output logic                         snax_pvalid_o,
  input  logic                         snax_pready_i,
  output acc_req_t [NumAcc-1:0]        snax_split_req_o,
  output logic     [NumAcc-1:0]        snax_split_qvalid_o,
  input  logic     [NumAcc-1:0]        snax_split_qready_i,
  input  acc_rsp_t [NumAcc-1:0]        snax_split_resp_i,
  input  logic     [NumAcc-1:0]        snax_split_pvalid_i,
  output logic     [NumAcc-1:0]        snax_split_pready_o,
  output logic     [CntWidth-1:0]      outst_cnt_o
);

`ifdef SNAX_ACC_ROUTER_ERR_RSP_EN
  // Index NumAcc marks an entry answered locally with an error.
  localparam int unsigned NumSel = NumAcc + 1;
`else
  localparam int unsigned NumSel = NumAcc;
`endif
  localparam int unsigned SelWidth = (NumSel > 1) ? $clog2(NumSel) : 1;

  csr_dec_t            dec;
  acc_req_t            fwd_req;
  logic                blocked, sel_qready, push, pop, full, empty;
  logic [SelWidth-1:0] push_sel, head_sel;
  logic [IdWidth-1:0]  head_id;

  // Request path: purely combinational, payload broadcast, qvalid only to the decoded port.
  always_comb begin
    dec                  = csr_decode(snax_req_i.data_argb, 32'(CsrBase), 32'(NumCsrs),
                                      32'(NumAcc));
    fwd_req              = snax_req_i;
    fwd_req.data_argb    = dec.local_off;
    blocked              = snax_rsp_exp_i && full;
    sel_qready           = 1'b0;
    push_sel             = '0;
    snax_split_req_o     = '0;
    snax_split_qvalid_o  = '0;
    for (int k = 0; k < NumAcc; k++) begin
      snax_split_req_o[k]    = fwd_req;
      snax_split_qvalid_o[k] = dec.valid && (dec.sel == 32'(k)) && snax_qvalid_i && !blocked;
      if (dec.sel == 32'(k)) begin
        sel_qready = snax_split_qready_i[k];
      end
    end
    if (dec.valid) begin
      snax_qready_o = sel_qready && !blocked;
      push_sel      = dec.sel[SelWidth-1:0];
    end else begin
`ifdef SNAX_ACC_ROUTER_ERR_RSP_EN
      snax_qready_o = !blocked;
      push_sel      = SelWidth'(NumAcc);
`else
      snax_qready_o = 1'b1;
`endif
    end
`ifdef SNAX_ACC_ROUTER_ERR_RSP_EN
    push = snax_qvalid_i && snax_qready_o && snax_rsp_exp_i;
`else
    push = snax_qvalid_i && snax_qready_o && snax_rsp_exp_i && dec.valid;
`endif
  end

  // Response path: only the port named by the FIFO head may hand back a response.
  always_comb begin
    snax_pvalid_o       = 1'b0;
    snax_resp_o         = '0;
    snax_split_pready_o = '0;
    if (!empty) begin
      for (int k = 0; k < NumAcc; k++) begin
        if (head_sel == SelWidth'(k)) begin
          snax_pvalid_o          = snax_split_pvalid_i[k];
          snax_resp_o            = snax_split_resp_i[k];
          snax_split_pready_o[k] = snax_pready_i;
        end
      end
`ifdef SNAX_ACC_ROUTER_ERR_RSP_EN
      if (head_sel == SelWidth'(NumAcc)) begin
        snax_pvalid_o     = 1'b1;
        snax_resp_o.id    = head_id;
        snax_resp_o.error = 1'b1;
        snax_resp_o.data  = '0;
      end
`endif
    end
    pop = snax_pvalid_o && snax_pready_i;
  end

`ifndef SNAX_ACC_ROUTER_ERR_RSP_EN
  logic unused_head_id;
  assign unused_head_id = ^head_id;
`endif

  snax_acc_order_fifo #(
    .Depth (MaxOutst),
    .Width (SelWidth + IdWidth)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  ({push_sel, snax_req_i.id}),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  ({head_sel, head_id}),
    .count_o (outst_cnt_o)
  );

endmodule

// File: tb/tb_snax_acc_ordered_router.sv
// Bench for snax_acc_ordered_router: a 2-port/depth-4 and a 3-port/depth-3 instance share core stimulus.
module tb_snax_acc_ordered_router;
  import snax_acc_router_pkg::*;

`ifdef SNAX_ACC_ROUTER_ERR_RSP_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_req_t   req;
  logic       rsp_exp, qvalid, pready;
  logic [2:0] i_sqrdy [2];
  logic [2:0] i_spval [2];
  acc_rsp_t   i_sprsp [2][3];

  logic                 a_qready, a_pvalid, b_qready, b_pvalid;
  acc_rsp_t             a_resp, b_resp;
  acc_req_t [1:0]       a_sreq;
  acc_req_t [2:0]       b_sreq;
  logic [1:0]           a_sqv, a_spr;
  logic [2:0]           b_sqv, b_spr;
  logic [2:0]           a_cnt;
  logic [1:0]           b_cnt;

  logic       o_qready [2];
  logic       o_pvalid [2];
  acc_rsp_t   o_resp   [2];
  acc_req_t   o_sreq   [2][3];
  logic [2:0] o_sqv    [2];
  logic [2:0] o_spr    [2];
  logic [2:0] o_cnt    [2];

  snax_acc_ordered_router #(
    .NumAcc   (2),
    .NumCsrs  (32),
    .CsrBase  (960),
    .MaxOutst (4)
  ) dut_a (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .snax_req_i          (req),
    .snax_rsp_exp_i      (rsp_exp),
    .snax_qvalid_i       (qvalid),
    .snax_qready_o       (a_qready),
    .snax_resp_o         (a_resp),
    .snax_pvalid_o       (a_pvalid),
    .snax_pready_i       (pready),
    .snax_split_req_o    (a_sreq),
    .snax_split_qvalid_o (a_sqv),
    .snax_split_qready_i (i_sqrdy[0][1:0]),
    .snax_split_resp_i   ({i_sprsp[0][1], i_sprsp[0][0]}),
    .snax_split_pvalid_i (i_spval[0][1:0]),
    .snax_split_pready_o (a_spr),
    .outst_cnt_o         (a_cnt)
  );

  snax_acc_ordered_router #(
    .NumAcc   (3),
    .NumCsrs  (32),
    .CsrBase  (960),
    .MaxOutst (3)
  ) dut_b (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .snax_req_i          (req),
    .snax_rsp_exp_i      (rsp_exp),
    .snax_qvalid_i       (qvalid),
    .snax_qready_o       (b_qready),
    .snax_resp_o         (b_resp),
    .snax_pvalid_o       (b_pvalid),
    .snax_pready_i       (pready),
    .snax_split_req_o    (b_sreq),
    .snax_split_qvalid_o (b_sqv),
    .snax_split_qready_i (i_sqrdy[1]),
    .snax_split_resp_i   ({i_sprsp[1][2], i_sprsp[1][1], i_sprsp[1][0]}),
    .snax_split_pvalid_i (i_spval[1]),
    .snax_split_pready_o (b_spr),
    .outst_cnt_o         (b_cnt)
  );

  always_comb begin
    o_qready[0] = a_qready;  o_qready[1] = b_qready;
    o_pvalid[0] = a_pvalid;  o_pvalid[1] = b_pvalid;
    o_resp[0]   = a_resp;    o_resp[1]   = b_resp;
    o_sqv[0]    = {1'b0, a_sqv};  o_sqv[1] = b_sqv;
    o_spr[0]    = {1'b0, a_spr};  o_spr[1] = b_spr;
    o_cnt[0]    = a_cnt;     o_cnt[1]    = {1'b0, b_cnt};
    o_sreq[0][0] = a_sreq[0]; o_sreq[0][1] = a_sreq[1]; o_sreq[0][2] = '0;
    o_sreq[1][0] = b_sreq[0]; o_sreq[1][1] = b_sreq[1]; o_sreq[1][2] = b_sreq[2];
  end

  // Reference state: per instance, the outstanding response order as sel*256+id.
  int unsigned ord_q [2][$];
  bit          manual, rand_resp;
  logic [2:0]  acc_mask [2];
  int          checks, errors;

  function automatic int nacc(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int mout(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [31:0] argb, input logic [5:0] id, input logic exp,
                         input logic vld);
    req.addr      = $urandom;
    req.data_arga = $urandom;
    req.data_argb = argb;
    req.data_argc = $urandom;
    req.data_op   = $urandom;
    req.id        = id;
    rsp_exp       = exp;
    qvalid        = vld;
  endtask

  // Accelerator models: each port answers its oldest outstanding id, in the order issued.
  task automatic drive_acc();
    if (!manual) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 3; k++) begin
          bit          found, en;
          int unsigned id;
          found = 1'b0;
          id    = 0;
          i_spval[d][k] = 1'b0;
          i_sprsp[d][k] = '0;
          for (int i = 0; i < ord_q[d].size(); i++) begin
            if (!found && (ord_q[d][i] / 256 == k)) begin
              found = 1'b1;
              id    = ord_q[d][i] % 256;
            end
          end
          en = rand_resp ? 1'($urandom_range(0, 1)) : acc_mask[d][k];
          if (k < nacc(d) && found && en) begin
            i_spval[d][k]       = 1'b1;
            i_sprsp[d][k].id    = 6'(id);
            i_sprsp[d][k].error = 1'b0;
            i_sprsp[d][k].data  = 32'hA000_0000 + 32'(d * 4096 + k * 256) + 32'(id);
          end
        end
      end
    end
  endtask

  // One clock: drive accelerators, check every output of both instances, advance the model.
  task automatic cyc();
    bit          push_e [2];
    bit          pop_e  [2];
    int unsigned enc_e  [2];
    drive_acc();
    #1;
    for (int d = 0; d < 2; d++) begin
      int          na;
      bit          v, full, blocked, eqr, epv;
      int unsigned sel, hs, hid;
      logic [31:0] off;
      logic [2:0]  eqv, epr;
      acc_rsp_t    ersp;
      acc_req_t    fwd;
      na      = nacc(d);
      off     = req.data_argb - 32'd960;
      v       = (req.data_argb >= 32'd960) && (off < 32'(na * 32));
      sel     = off / 32;
      full    = (ord_q[d].size() == mout(d));
      blocked = rsp_exp && full;
      eqv     = '0;
      if (v) begin
        eqv[sel] = qvalid && !blocked;
        eqr      = i_sqrdy[d][sel] && !blocked;
      end else begin
        eqr = ErrEn ? !blocked : 1'b1;
      end
      fwd           = req;
      fwd.data_argb = off % 32;
      for (int k = 0; k < na; k++) begin
        chk($sformatf("d%0d_split_req%0d", d, k), o_sreq[d][k], fwd);
      end
      chk($sformatf("d%0d_split_qvalid", d), o_sqv[d], eqv);
      chk($sformatf("d%0d_qready", d), o_qready[d], eqr);
      epv  = 1'b0;
      epr  = '0;
      ersp = '0;
      if (ord_q[d].size() > 0) begin
        hs  = ord_q[d][0] / 256;
        hid = ord_q[d][0] % 256;
        if (hs == na) begin
          epv        = 1'b1;
          ersp.id    = 6'(hid);
          ersp.error = 1'b1;
        end else begin
          epv     = i_spval[d][hs];
          ersp    = i_sprsp[d][hs];
          epr[hs] = pready;
        end
      end
      chk($sformatf("d%0d_pvalid", d), o_pvalid[d], epv);
      chk($sformatf("d%0d_split_pready", d), o_spr[d], epr);
      chk($sformatf("d%0d_outst_cnt", d), o_cnt[d], ord_q[d].size());
      if (epv) chk($sformatf("d%0d_resp", d), o_resp[d], ersp);
      pop_e[d]  = epv && pready;
      push_e[d] = qvalid && eqr && rsp_exp && (v || ErrEn);
      enc_e[d]  = (v ? sel : na) * 256 + req.id;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (pop_e[d]) void'(ord_q[d].pop_front());
      if (push_e[d]) ord_q[d].push_back(enc_e[d]);
    end
    #1;
  endtask

  task automatic do_reset();
    qvalid = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ord_q[0].delete();
    ord_q[1].delete();
  endtask

  task automatic drain(input int budget);
    int n;
    n           = 0;
    qvalid      = 1'b0;
    pready      = 1'b1;
    rand_resp   = 1'b0;
    acc_mask[0] = 3'b111;
    acc_mask[1] = 3'b111;
    while ((ord_q[0].size() + ord_q[1].size()) > 0 && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_cnt_a", o_cnt[0], 0);
    chk("drain_cnt_b", o_cnt[1], 0);
  endtask

  initial begin
    acc_rsp_t    hold, err_rsp;
    logic [31:0] bounds [10];
    checks = 0;
    errors = 0;
    manual = 1'b0;
    rand_resp = 1'b0;
    acc_mask[0] = '0;
    acc_mask[1] = '0;
    i_sqrdy[0] = 3'b111;
    i_sqrdy[1] = 3'b111;
    pready = 1'b1;
    set_req(32'd0, 6'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    do_reset();
    cyc();

    // Write to acc1, local offset 8, nothing outstanding.
    set_req(32'd1000, 6'd1, 1'b0, 1'b1);
    drive_acc();
    #1;
    chk("wr1000_qvalid", o_sqv[0], 3'b010);
    chk("wr1000_argb", o_sreq[0][1].data_argb, 32'd8);
    cyc();
    chk("wr1000_cnt", o_cnt[0], 3'd0);

    // Two reads; acc1 answers first and must wait behind acc0.
    set_req(32'd961, 6'd3, 1'b1, 1'b1);
    cyc();
    set_req(32'd993, 6'd4, 1'b1, 1'b1);
    cyc();
    chk("two_reads_cnt", o_cnt[0], 3'd2);
    qvalid = 1'b0;
    acc_mask[0] = 3'b010;
    acc_mask[1] = 3'b010;
    drive_acc();
    #1;
    chk("acc1_stalled_pready", o_spr[0][1], 1'b0);
    chk("acc1_stalled_pvalid", o_pvalid[0], 1'b0);
    cyc();
    acc_mask[0] = 3'b011;
    acc_mask[1] = 3'b011;
    drive_acc();
    #1;
    chk("first_resp_id", o_resp[0].id, 6'd3);
    cyc();
    chk("after_first_cnt", o_cnt[0], 3'd1);
    chk("second_resp_id", o_resp[0].id, 6'd4);
    cyc();
    chk("after_second_cnt", o_cnt[0], 3'd0);

    // Fill the order FIFO, then probe full behaviour.
    acc_mask[0] = '0;
    acc_mask[1] = '0;
    for (int i = 0; i < 4; i++) begin
      set_req(32'd960 + 32'($urandom_range(0, 63)), 6'(i), 1'b1, 1'b1);
      cyc();
    end
    set_req(32'd970, 6'd5, 1'b1, 1'b1);
    drive_acc();
    #1;
    chk("full_qready", o_qready[0], 1'b0);
    chk("full_qvalid", o_sqv[0], 3'b000);
    cyc();
    set_req(32'd1000, 6'd6, 1'b0, 1'b1);
    drive_acc();
    #1;
    chk("full_write_qready", o_qready[0], 1'b1);
    cyc();
    set_req(32'd975, 6'd9, 1'b1, 1'b1);
    acc_mask[0] = 3'b111;
    acc_mask[1] = 3'b111;
    drive_acc();
    #1;
    chk("pop_push_qready", o_qready[0], 1'b0);
    chk("pop_push_pvalid", o_pvalid[0], 1'b1);
    cyc();
    chk("pop_push_cnt", o_cnt[0], 3'd3);
    acc_mask[0] = '0;
    acc_mask[1] = '0;
    drive_acc();
    #1;
    chk("push_next_qready", o_qready[0], 1'b1);
    cyc();
    chk("push_next_cnt", o_cnt[0], 3'd4);

    // Backpressure: head response held steady while the core stalls.
    qvalid = 1'b0;
    pready = 1'b0;
    acc_mask[0] = 3'b111;
    acc_mask[1] = 3'b111;
    drive_acc();
    #1;
    hold = o_resp[0];
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_resp_stable", o_resp[0], hold);
      chk("bp_cnt", o_cnt[0], 3'd4);
    end
    drain(40);

    // Out-of-range read.
    set_req(32'd2000, 6'd7, 1'b1, 1'b1);
    acc_mask[0] = '0;
    acc_mask[1] = '0;
    drive_acc();
    #1;
    chk("oor_qvalid", o_sqv[0], 3'b000);
    chk("oor_qready", o_qready[0], 1'b1);
    cyc();
    chk("oor_cnt", o_cnt[0], 3'(ErrEn));
    qvalid = 1'b0;
    drive_acc();
    #1;
    err_rsp.id    = 6'd7;
    err_rsp.error = 1'b1;
    err_rsp.data  = '0;
    chk("oor_pvalid", o_pvalid[0], ErrEn);
    chk("oor_resp", o_pvalid[0] ? o_resp[0] : '0, ErrEn ? err_rsp : '0);
    cyc();
    chk("oor_cnt_after", o_cnt[0], 3'd0);

    // Window edges, writes and reads.
    bounds = '{32'd959, 32'd960, 32'd991, 32'd992, 32'd1023, 32'd1024, 32'd1055, 32'd1056,
               32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 10; i++) begin
      set_req(bounds[i], 6'(i), 1'(i % 2), 1'b1);
      cyc();
    end
    drain(40);

    // Reset with two reads outstanding; late responses must be stalled.
    set_req(32'd961, 6'd1, 1'b1, 1'b1);
    cyc();
    set_req(32'd993, 6'd2, 1'b1, 1'b1);
    cyc();
    do_reset();
    manual = 1'b1;
    for (int d = 0; d < 2; d++) begin
      i_spval[d] = 3'b111;
      for (int k = 0; k < 3; k++) begin
        i_sprsp[d][k] = '{id: 6'(k + 1), error: 1'b0, data: 32'hDEAD_0000};
      end
    end
    #1;
    chk("rst_cnt", o_cnt[0], 3'd0);
    chk("rst_pvalid", o_pvalid[0], 1'b0);
    chk("rst_split_pready", o_spr[0], 3'b000);
    cyc();
    manual = 1'b0;

    // Random traffic with random accelerator timing and core backpressure.
    rand_resp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      set_req(32'd940 + 32'($urandom_range(0, 130)), 6'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0);
      pready     = $urandom_range(0, 3) != 0;
      i_sqrdy[0] = 3'($urandom);
      i_sqrdy[1] = 3'($urandom);
      cyc();
    end
    i_sqrdy[0] = 3'b111;
    i_sqrdy[1] = 3'b111;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
